// File: rtl/mux_tree_ctrl_pkg.sv
// Shared types and the channel-select to air-line mapping for the valve-tree controller.

package mux_tree_ctrl_pkg;

    localparam int unsigned MAX_LEVELS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_OPEN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [MAX_LEVELS-1:0] c1;
        logic [MAX_LEVELS-1:0] c0;
    } ctrl_pair_t;

    // Level L is steered by sel bit (levels-L), so ctrl_0 is sel bit-reversed over `levels` bits.
    function automatic ctrl_pair_t sel_to_ctrl(input logic [MAX_LEVELS-1:0] sel,
                                               input int unsigned levels);
        ctrl_pair_t            p;
        logic [MAX_LEVELS-1:0] s;
        logic [MAX_LEVELS-1:0] r;
        s = sel;
        r = '0;
        for (int unsigned i = 0; i < MAX_LEVELS; i++) begin
            if (i < levels) begin
                r = {r[MAX_LEVELS-2:0], s[0]};
                s = s >> 1;
            end
        end
        p.c0 = r;
        p.c1 = ~r;
        return p;
    endfunction

endpackage

// File: rtl/mux_tree_timer.sv
// Load/decrement counter with zero flag, shared by the settle and dwell phases.

module mux_tree_timer
    import mux_tree_ctrl_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mux_tree_ctrl.sv
// Break-before-make controller for a binary pneumatic valve tree with timed or held paths.

module mux_tree_ctrl
    import mux_tree_ctrl_pkg::*;
#(
    parameter int unsigned LEVELS        = 6,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DWELL_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LEVELS-1:0]  req_sel,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               release_req,
    output logic [LEVELS-1:0]  ctrl_0,
    output logic [LEVELS-1:0]  ctrl_1,
    output logic               path_open,
    output logic [LEVELS-1:0]  cur_sel,
    output logic               done
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e              state_q,      state_d;
    logic [LEVELS-1:0]   cur_sel_q,    cur_sel_d;
    logic [DWELL_W-1:0]  dwell_q,      dwell_d;
    logic                pend_q,       pend_d;
    logic [LEVELS-1:0]   pend_sel_q,   pend_sel_d;
    logic [DWELL_W-1:0]  pend_dwell_q, pend_dwell_d;
    logic [LEVELS-1:0]   ctrl_0_q,     ctrl_0_d;
    logic [LEVELS-1:0]   ctrl_1_q,     ctrl_1_d;
    logic                path_open_q,  path_open_d;
    logic                done_q,       done_d;
    logic                req_ready_q,  req_ready_d;

    logic                tmr_load;
    logic                tmr_dec;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                accept;
    logic                drive_open;
    ctrl_pair_t          open_pair;
    logic                unused_pair_bits;

    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return CNT_W'(d) - CNT_W'(1);
    endfunction

    mux_tree_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    // Release outranks a same-cycle request while a path is open.
    assign req_ready = req_ready_q & ~(release_req & path_open_q);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d      = state_q;
        cur_sel_d    = cur_sel_q;
        dwell_d      = dwell_q;
        pend_d       = pend_q;
        pend_sel_d   = pend_sel_q;
        pend_dwell_d = pend_dwell_q;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_val      = SETTLE_LOAD;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_MAKE;
                    cur_sel_d = req_sel;
                    dwell_d   = req_dwell;
                    tmr_load  = 1'b1;
                end
            end
            ST_MAKE: begin
                if (tmr_zero) begin
                    state_d  = ST_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = dwell_load(dwell_q);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_OPEN: begin
                if (release_req) begin
                    state_d  = ST_BREAK;
                    pend_d   = 1'b0;
                    tmr_load = 1'b1;
                end else if (accept && (req_sel != cur_sel_q)) begin
                    state_d      = ST_BREAK;
                    pend_d       = 1'b1;
                    pend_sel_d   = req_sel;
                    pend_dwell_d = req_dwell;
                    tmr_load     = 1'b1;
                end else if (accept) begin
                    // Same channel: keep the valves where they are, only restart the dwell.
                    dwell_d  = req_dwell;
                    tmr_load = 1'b1;
                    tmr_val  = dwell_load(req_dwell);
                end else if (dwell_q != '0) begin
                    if (tmr_zero) begin
                        state_d  = ST_BREAK;
                        pend_d   = 1'b0;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (tmr_zero) begin
                    if (pend_q) begin
                        state_d   = ST_MAKE;
                        cur_sel_d = pend_sel_q;
                        dwell_d   = pend_dwell_q;
                        pend_d    = 1'b0;
                        tmr_load  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        open_pair   = sel_to_ctrl(MAX_LEVELS'(cur_sel_d), LEVELS);
        drive_open  = (state_d == ST_MAKE) || (state_d == ST_OPEN);
        ctrl_0_d    = drive_open ? open_pair.c0[LEVELS-1:0] : '1;
        ctrl_1_d    = drive_open ? open_pair.c1[LEVELS-1:0] : '1;
        path_open_d = (state_d == ST_OPEN);
        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_OPEN);
        done_d      = (state_q == ST_BREAK) && (state_d == ST_IDLE);
    end

    assign unused_pair_bits = ^open_pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_sel_q    <= '0;
            dwell_q      <= '0;
            pend_q       <= 1'b0;
            pend_sel_q   <= '0;
            pend_dwell_q <= '0;
            ctrl_0_q     <= '1;
            ctrl_1_q     <= '1;
            path_open_q  <= 1'b0;
            done_q       <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            dwell_q      <= dwell_d;
            pend_q       <= pend_d;
            pend_sel_q   <= pend_sel_d;
            pend_dwell_q <= pend_dwell_d;
            ctrl_0_q     <= ctrl_0_d;
            ctrl_1_q     <= ctrl_1_d;
            path_open_q  <= path_open_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign ctrl_0    = ctrl_0_q;
    assign ctrl_1    = ctrl_1_q;
    assign path_open = path_open_q;
    assign cur_sel   = cur_sel_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_tree_ctrl.sv
// Scoreboard bench: a timeline model schedules expected per-cycle outputs, a monitor compares them.

module tb_mux_tree_ctrl;

    localparam int unsigned LV = 6;
    localparam int unsigned ST = 4;
    localparam int unsigned DW = 16;

    localparam int T_RST  = 0;
    localparam int T_IDLE = 1;
    localparam int T_MK   = 2;
    localparam int T_OP   = 3;
    localparam int T_BRK  = 4;
    localparam int T_DONE = 5;

    typedef struct packed {
        logic [2:0]    typ;
        logic [LV-1:0] sel;
    } ent_t;

    typedef struct packed {
        logic [LV-1:0] c0;
        logic [LV-1:0] c1;
        logic          po;
        logic [LV-1:0] cs;
        logic          dn;
        logic          rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LV-1:0] req_sel = '0;
    logic [DW-1:0] req_dwell = '0;
    logic          release_req = 1'b0;
    logic [LV-1:0] ctrl_0;
    logic [LV-1:0] ctrl_1;
    logic          path_open;
    logic [LV-1:0] cur_sel;
    logic          done;

    always #5 clk = ~clk;

    mux_tree_ctrl #(
        .LEVELS        (LV),
        .SETTLE_CYCLES (ST),
        .DWELL_W       (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_dwell   (req_dwell),
        .release_req (release_req),
        .ctrl_0      (ctrl_0),
        .ctrl_1      (ctrl_1),
        .path_open   (path_open),
        .cur_sel     (cur_sel),
        .done        (done)
    );

    exp_t          exp_q[$];
    ent_t          sched[$];
    ent_t          cur;
    bit            hold = 1'b0;
    logic [LV-1:0] hold_sel = '0;
    bit            p_valid = 1'b0;
    logic [LV-1:0] p_sel = '0;
    logic [DW-1:0] p_dwell = '0;
    bit            p_rel = 1'b0;
    bit            p_rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int po_cnt = 0;
    int done_cnt = 0;
    int s7_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bit reversal by repeated division, independent of any vector slicing.
    function automatic logic [LV-1:0] rev(input logic [LV-1:0] s);
        int r;
        int v;
        r = 0;
        v = int'(s);
        for (int i = 0; i < int'(LV); i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return LV'(r);
    endfunction

    function automatic bit exp_ready(input ent_t e, input bit rel);
        return (e.typ == 3'(T_IDLE)) || (e.typ == 3'(T_DONE)) || ((e.typ == 3'(T_OP)) && !rel);
    endfunction

    function automatic exp_t make_exp(input ent_t e, input bit rel);
        exp_t          x;
        logic [LV-1:0] r;
        bit            opn;
        r    = rev(e.sel);
        opn  = (e.typ == 3'(T_MK)) || (e.typ == 3'(T_OP));
        x.c0 = opn ? r : '1;
        x.c1 = opn ? ~r : '1;
        x.po = (e.typ == 3'(T_OP));
        x.cs = e.sel;
        x.dn = (e.typ == 3'(T_DONE));
        x.rdy = exp_ready(e, rel);
        return x;
    endfunction

    task automatic push_n(input int typ, input logic [LV-1:0] s, input int n);
        ent_t e;
        e.typ = 3'(typ);
        e.sel = s;
        for (int i = 0; i < n; i++) sched.push_back(e);
    endtask

    task automatic plan_open(input logic [LV-1:0] s, input logic [DW-1:0] d);
        if (d != '0) begin
            hold = 1'b0;
            push_n(T_OP, s, int'(d));
            push_n(T_BRK, s, int'(ST));
            push_n(T_DONE, s, 1);
        end else begin
            hold     = 1'b1;
            hold_sel = s;
        end
    endtask

    task automatic plan_new(input logic [LV-1:0] s, input logic [DW-1:0] d);
        push_n(T_MK, s, int'(ST));
        plan_open(s, d);
    endtask

    // Advance the timeline across one clock edge given the inputs seen at that edge.
    task automatic model_step();
        bit   acc;
        ent_t nxt;
        if (p_rst) begin
            sched.delete();
            hold    = 1'b0;
            cur.typ = 3'(T_RST);
            cur.sel = '0;
            return;
        end
        acc = p_valid && exp_ready(cur, p_rel);
        if ((cur.typ == 3'(T_IDLE)) || (cur.typ == 3'(T_DONE))) begin
            if (acc) plan_new(p_sel, p_dwell);
        end else if (cur.typ == 3'(T_OP)) begin
            if (p_rel) begin
                hold = 1'b0;
                sched.delete();
                push_n(T_BRK, cur.sel, int'(ST));
                push_n(T_DONE, cur.sel, 1);
            end else if (acc && (p_sel != cur.sel)) begin
                hold = 1'b0;
                sched.delete();
                push_n(T_BRK, cur.sel, int'(ST));
                plan_new(p_sel, p_dwell);
            end else if (acc) begin
                sched.delete();
                plan_open(p_sel, p_dwell);
            end
        end
        if (sched.size() > 0) begin
            nxt = sched.pop_front();
        end else if (hold) begin
            nxt.typ = 3'(T_OP);
            nxt.sel = hold_sel;
        end else begin
            nxt.typ = 3'(T_IDLE);
            nxt.sel = cur.sel;
        end
        cur = nxt;
    endtask

    task automatic cycle(input bit v, input logic [LV-1:0] s, input logic [DW-1:0] d,
                         input bit rel, input bit r);
        @(posedge clk);
        #1;
        model_step();
        req_valid   = v;
        req_sel     = s;
        req_dwell   = d;
        release_req = rel;
        rst         = r;
        exp_q.push_back(make_exp(cur, rel));
        p_valid = v;
        p_sel   = s;
        p_dwell = d;
        p_rel   = rel;
        p_rst   = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented cycle and watch for direct open-to-open switches.
    logic [LV-1:0] prev_c0 = '1;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ctrl_0", 32'(ctrl_0), 32'(e.c0));
            chk("ctrl_1", 32'(ctrl_1), 32'(e.c1));
            chk("path_open", 32'(path_open), 32'(e.po));
            chk("cur_sel", 32'(cur_sel), 32'(e.cs));
            chk("done", 32'(done), 32'(e.dn));
            chk("req_ready", 32'(req_ready), 32'(e.rdy));
            if ((prev_c0 != '1) && (ctrl_0 != '1)) begin
                chk("open_to_open", 32'(ctrl_0), 32'(prev_c0));
            end
            prev_c0 = ctrl_0;
            if (path_open === 1'b1) po_cnt++;
            if (done === 1'b1) done_cnt++;
            if ((ctrl_0 == rev(6'd7)) && (ctrl_1 == ~rev(6'd7))) s7_cnt++;
        end
    end

    initial begin
        int base_po;
        int base_dn;
        int base_s7;
        cur.typ = 3'(T_RST);
        cur.sel = '0;

        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        idle(3);

        // Held path on sel 5, then switch to sel 6, then release.
        cycle(1'b1, 6'd5, 16'd0, 1'b0, 1'b0);
        idle(8);
        cycle(1'b1, 6'd6, 16'd0, 1'b0, 1'b0);
        idle(12);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        idle(8);

        // Timed dwell of 3 cycles.
        base_po = po_cnt;
        base_dn = done_cnt;
        cycle(1'b1, 6'd9, 16'd3, 1'b0, 1'b0);
        idle(14);
        chk("dwell3_open_cycles", 32'(po_cnt - base_po), 32'd3);
        chk("dwell3_done_pulses", 32'(done_cnt - base_dn), 32'd1);

        // Release beats a same-cycle request for another channel.
        cycle(1'b1, 6'd5, 16'd0, 1'b0, 1'b0);
        idle(7);
        base_dn = done_cnt;
        base_s7 = s7_cnt;
        cycle(1'b1, 6'd7, 16'd0, 1'b1, 1'b0);
        idle(8);
        chk("release_done_pulses", 32'(done_cnt - base_dn), 32'd1);
        chk("sel7_never_driven", 32'(s7_cnt - base_s7), 32'd0);

        // Same-channel re-request reloads dwell without touching the valves.
        base_po = po_cnt;
        cycle(1'b1, 6'd2, 16'd10, 1'b0, 1'b0);
        idle(9);
        cycle(1'b1, 6'd2, 16'd10, 1'b0, 1'b0);
        idle(20);
        chk("reload_open_cycles", 32'(po_cnt - base_po), 32'd16);

        // Reset while making a path.
        base_dn = done_cnt;
        cycle(1'b1, 6'd3, 16'd0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        idle(6);
        chk("reset_no_done", 32'(done_cnt - base_dn), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            bit            v;
            bit            rel;
            bit            r;
            logic [LV-1:0] s;
            logic [DW-1:0] d;
            v   = ($urandom_range(0, 99) < 25);
            rel = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 1) == 0) ? cur.sel : LV'($urandom_range(0, 63));
            d   = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom_range(1, 12));
            cycle(v, s, d, rel, r);
        end
        idle(4);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
